// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller producing the CPU clock from sysclk with a programmable divider.
// Optional cycle counter is built only when CPU_CLK_CTRL_CYCLE_CNT_EN is defined.
module cpu_clk_ctrl #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  output logic             clk,
  output logic             cpu_tick,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_DRAIN = 2'd3
  } st_t;

  st_t              st;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic             halted;
  logic             step_q;

  logic toggle;
  logic rise;
  logic step_edge;
  logic stop;

  assign toggle    = (cnt == div_q);
  assign rise      = toggle && !clk && (st != S_HALT);
  assign step_edge = step_req && !step_q;
  assign stop      = halt_req || !run_req;
  assign state     = st;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      st       <= S_HALT;
      clk      <= 1'b1;
      cpu_tick <= 1'b0;
      cnt      <= '0;
      div_q    <= '0;
      halted   <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      cpu_tick <= rise;
      step_q   <= step_req;
      // a breakpoint latches until the host drops run_req
      if (!run_req)
        halted <= 1'b0;
      else if (st == S_RUN && halt_req)
        halted <= 1'b1;

      case (st)
        S_HALT: begin
          cnt <= '0;
          clk <= 1'b1;
          if (run_req && !halted) begin
            st    <= S_RUN;
            div_q <= div;
          end else if (step_edge) begin
            st    <= S_STEP;
            div_q <= div;
          end
        end
        S_RUN: begin
          if (toggle) begin
            clk   <= ~clk;
            cnt   <= '0;
            div_q <= div;
            // stopping on a rising toggle completes the cycle directly
            if (stop)
              st <= clk ? S_DRAIN : S_HALT;
          end else begin
            cnt <= cnt + 1'b1;
            if (stop) begin
              if (clk) begin
                st  <= S_HALT;
                cnt <= '0;
              end else begin
                st <= S_DRAIN;
              end
            end
          end
        end
        default: begin
          // STEP and DRAIN both run to the next rising toggle, then halt
          if (toggle) begin
            clk   <= ~clk;
            cnt   <= '0;
            div_q <= div;
            if (!clk)
              st <= S_HALT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
  always_ff @(posedge sysclk) begin
    if (reset)
      cycle_cnt <= '0;
    else if (rise)
      cycle_cnt <= cycle_cnt + 1'b1;
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule
